// File: rtl/inst_loader_pkg.sv
// ============================================================================
// inst_loader_pkg : shared types and constants for the instruction loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package inst_loader_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    EXEC = 1'b1
  } mode_t;

  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_INST  = 3'd1,
    S_WRITE = 3'd2,
    S_START = 3'd3,
    S_RUN   = 3'd4,
    S_ERR   = 3'd5
  } loader_state_t;

  localparam int LEN_BYTES = 4;
  localparam int LEN_WIDTH = 32;

  function automatic int bytes_per_inst(input int inst_width);
    return inst_width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_loader_byte_assembler.sv
// ============================================================================
// inst_loader_byte_assembler : big-endian byte shifter with a modulo counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_loader_byte_assembler #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_byte_i,
  input  logic [CNT_W-1:0]  width_i,
  output logic [WORD_W-1:0] out_word_o,
  output logic              out_last_o
);

  // Only the earlier bytes are stored; the current byte completes the word.
  logic [WORD_W-9:0] word_q;
  logic [CNT_W-1:0]  cnt_q;

  assign out_word_o = {word_q, in_byte_i};
  assign out_last_o = in_valid_i && (cnt_q == width_i - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (in_valid_i) begin
      word_q <= out_word_o[WORD_W-9:0];
      cnt_q  <= out_last_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_loader.sv
// ============================================================================
// inst_loader : boot loader writing a length-prefixed UART byte stream to imem.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int INST_WIDTH     = 32,
  parameter int INST_MEM_WIDTH = 13
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    reload,
  output mode_t                   mode,
  output logic                    we,
  output logic [INST_WIDTH-1:0]   inst_out,
  output logic                    stall_req,
  output logic                    reset_pc,
  output logic                    done,
  output logic                    error,
  output logic [INST_MEM_WIDTH:0] words_loaded
);

  localparam int BYTES_PER_INST = bytes_per_inst(INST_WIDTH);
  localparam int MAX_BYTES      = (BYTES_PER_INST > LEN_BYTES) ? BYTES_PER_INST : LEN_BYTES;
  localparam int WORD_W         = MAX_BYTES * 8;
  localparam int CNT_W          = $clog2(MAX_BYTES) + 1;
  localparam logic [LEN_WIDTH:0] CAPACITY = {{LEN_WIDTH{1'b0}}, 1'b1} << INST_MEM_WIDTH;

  loader_state_t          state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [INST_MEM_WIDTH:0] wl_q;

  mode_t mode_d;
  logic  we_d, stall_d, reset_pc_d, done_d, error_d;

  logic              w_asm_valid, w_asm_clear, w_asm_last, w_last_word;
  logic [CNT_W-1:0]  w_width;
  logic [WORD_W-1:0] w_word;
  logic [LEN_WIDTH-1:0]  w_len_rx;
  logic [INST_WIDTH-1:0] w_inst_rx;

  // Bytes outside the loading states never reach the assembler.
  assign w_asm_valid = rx_valid && (state_q inside {S_LEN, S_INST, S_WRITE});
  assign w_asm_clear = state_q inside {S_START, S_RUN, S_ERR};
  assign w_width     = (state_q == S_LEN) ? CNT_W'(LEN_BYTES) : CNT_W'(BYTES_PER_INST);
  assign w_len_rx    = w_word[LEN_WIDTH-1:0];
  assign w_inst_rx   = w_word[INST_WIDTH-1:0];
  assign w_last_word = (LEN_WIDTH'(wl_q) + LEN_WIDTH'(1)) == len_q;
  assign words_loaded = wl_q;

  inst_loader_byte_assembler #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (w_asm_clear),
    .in_valid_i (w_asm_valid),
    .in_byte_i  (rx_data),
    .width_i    (w_width),
    .out_word_o (w_word),
    .out_last_o (w_asm_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LEN;
      mode      <= LOAD;
      we        <= 1'b0;
      stall_req <= 1'b1;
      reset_pc  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode      <= mode_d;
      we        <= we_d;
      stall_req <= stall_d;
      reset_pc  <= reset_pc_d;
      done      <= done_d;
      error     <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN: begin
        if (w_asm_last) begin
          if (w_len_rx == '0)                  state_d = S_START;
          else if ({1'b0, w_len_rx} > CAPACITY) state_d = S_ERR;
          else                                 state_d = S_INST;
        end
      end
      S_INST:  if (w_asm_last) state_d = S_WRITE;
      // A byte arriving here may itself complete a word when words are one byte wide.
      S_WRITE: begin
        if (w_last_word)     state_d = S_START;
        else if (w_asm_last) state_d = S_WRITE;
        else                 state_d = S_INST;
      end
      S_START: state_d = S_RUN;
      S_RUN:   if (reload) state_d = S_LEN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_LEN;
    endcase
  end

  always_comb begin
    mode_d     = (state_d == S_RUN) ? EXEC : LOAD;
    we_d       = (state_d == S_WRITE);
    stall_d    = !(state_d inside {S_WRITE, S_RUN});
    reset_pc_d = (state_d inside {S_LEN, S_START});
    done_d     = (state_d == S_RUN);
    error_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      wl_q     <= '0;
      inst_out <= '0;
    end else begin
      if (state_q == S_LEN && w_asm_last) len_q <= w_len_rx;
      if (state_q == S_RUN && reload)     wl_q  <= '0;
      else if (state_q == S_WRITE)        wl_q  <= wl_q + 1'b1;
      if (state_d == S_WRITE && w_asm_last) inst_out <= w_inst_rx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
// ============================================================================
// tb_inst_loader : directed self-checking bench with a word scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inst_loader;
  import inst_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        reload = 1'b0;
  mode_t       mode;
  logic        we;
  logic [31:0] inst_out;
  logic        stall_req, reset_pc, done, error;
  logic [13:0] words_loaded;

  int checks = 0;
  int failures = 0;
  int we_count = 0;
  logic [31:0] last_word = 32'h0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  inst_loader dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .reload(reload),
    .mode(mode), .we(we), .inst_out(inst_out), .stall_req(stall_req), .reset_pc(reset_pc),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  // Per-cycle scoreboard: every write must match the next expected word, and the
  // status outputs must be mutually consistent.
  always @(negedge clk) begin
    logic [31:0] e;
    checks++;
    if (stall_req !== !(we === 1'b1 || mode === EXEC) || done !== (mode === EXEC) ||
        (error === 1'b1 && (we !== 1'b0 || mode !== LOAD))) begin
      failures++;
      $display("FAIL invariant t=%0t stall=%b we=%b mode=%0d done=%b error=%b",
               $time, stall_req, we, mode, done, error);
    end
    if (we === 1'b1) begin
      checks++;
      we_count++;
      last_word = inst_out;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_we t=%0t got=%h required=no write", $time, inst_out);
      end else begin
        e = exp_q.pop_front();
        if (inst_out !== e) begin
          failures++;
          $display("FAIL inst_out t=%0t got=%h required=%h", $time, inst_out, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      repeat (gap) tick();
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, {63'd0, done}, 64'd1);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_mode"},  {63'd0, mode}, 64'd0);
    chk({name, "_we"},    {63'd0, we}, 64'd0);
    chk({name, "_stall"}, {63'd0, stall_req}, 64'd1);
    chk({name, "_rstpc"}, {63'd0, reset_pc}, 64'd1);
    chk({name, "_inst"},  {32'd0, inst_out}, 64'd0);
    chk({name, "_done"},  {63'd0, done}, 64'd0);
    chk({name, "_error"}, {63'd0, error}, 64'd0);
    chk({name, "_wl"},    {50'd0, words_loaded}, 64'd0);
  endtask

  initial begin
    int base;
    logic [31:0] w;
    repeat (2) tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Empty program: straight to handover.
    base = we_count;
    send_word(32'h0, 0);
    chk("len0_rstpc_start", {63'd0, reset_pc}, 64'd1);
    chk("len0_mode_start", {63'd0, mode}, 64'd0);
    tick();
    chk("len0_mode_exec", {63'd0, mode}, 64'd1);
    chk("len0_done", {63'd0, done}, 64'd1);
    chk("len0_no_we", we_count - base, 0);

    // Bytes in RUN are discarded; reload restarts loading.
    send_byte(8'h55);
    send_byte(8'hAA);
    pulse_reload();
    chk("reload_mode", {63'd0, mode}, 64'd0);
    chk("reload_rstpc", {63'd0, reset_pc}, 64'd1);
    chk("reload_done", {63'd0, done}, 64'd0);

    // Two words with idle gaps between bytes.
    base = we_count;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h01234567);
    send_word(32'd2, 1);
    send_word(32'hDEADBEEF, 1);
    send_word(32'h01234567, 2);
    wait_done("len2_done", 10);
    chk("len2_we", we_count - base, 2);
    chk("len2_wl", {50'd0, words_loaded}, 64'd2);
    chk("len2_last", {32'd0, last_word}, 64'h01234567);
    chk("len2_queue", exp_q.size(), 0);

    // Back-to-back bytes, including during the write cycle.
    pulse_reload();
    base = we_count;
    exp_q.push_back(32'h11223344);
    exp_q.push_back(32'hA5A55A5A);
    exp_q.push_back(32'hF00DFACE);
    send_word(32'd3, 0);
    send_word(32'h11223344, 0);
    send_word(32'hA5A55A5A, 0);
    send_word(32'hF00DFACE, 0);
    wait_done("b2b_done", 10);
    chk("b2b_we", we_count - base, 3);
    chk("b2b_wl", {50'd0, words_loaded}, 64'd3);
    chk("b2b_queue", exp_q.size(), 0);

    // Single-word reload.
    pulse_reload();
    base = we_count;
    exp_q.push_back(32'hCAFEBABE);
    send_word(32'd1, 0);
    send_word(32'hCAFEBABE, 1);
    wait_done("cafe_done", 10);
    chk("cafe_we", we_count - base, 1);
    chk("cafe_last", {32'd0, last_word}, 64'hCAFEBABE);
    chk("cafe_mode", {63'd0, mode}, 64'd1);

    // Full-capacity load is legal.
    pulse_reload();
    base = we_count;
    send_word(32'd8192, 0);
    for (int i = 0; i < 8192; i++) begin
      w = 32'h3C000000 + i * 32'h00010203;
      exp_q.push_back(w);
      send_word(w, 0);
    end
    wait_done("cap_done", 10);
    chk("cap_we", we_count - base, 8192);
    chk("cap_wl", {50'd0, words_loaded}, 64'd8192);
    chk("cap_error", {63'd0, error}, 64'd0);
    chk("cap_queue", exp_q.size(), 0);

    // Oversized program: sticky error.
    pulse_reload();
    base = we_count;
    send_word(32'h00002001, 0);
    chk("err_flag", {63'd0, error}, 64'd1);
    send_word(32'h12345678, 0);
    send_word(32'h9ABCDEF0, 0);
    pulse_reload();
    repeat (3) tick();
    chk("err_sticky", {63'd0, error}, 64'd1);
    chk("err_mode", {63'd0, mode}, 64'd0);
    chk("err_no_we", we_count - base, 0);

    // Asynchronous reset in the middle of a word.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    send_word(32'd1, 0);
    send_byte(8'h77);
    send_byte(8'h66);
    chk("mid_rstpc_before", {63'd0, reset_pc}, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    base = we_count;
    exp_q.push_back(32'h89ABCDEF);
    send_word(32'd1, 0);
    send_word(32'h89ABCDEF, 0);
    wait_done("after_rst_done", 10);
    chk("after_rst_we", we_count - base, 1);
    chk("after_rst_last", {32'd0, last_word}, 64'h89ABCDEF);
    chk("after_rst_wl", {50'd0, words_loaded}, 64'd1);
    chk("after_rst_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
